// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte FSM state encoding and
// character-format constants.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Two-flop synchronizer plus 8N1 byte receiver. Each bit is sampled near its
// centre; byte_valid and frame_err are one-cycle registered pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 idle
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rxs;
    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick;
    logic                 valid_next;
    logic                 err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_reg <= 2'b11;
        else     sync_reg <= {sync_reg[0], rx_serial};
    end

    assign rxs = sync_reg[1];

    // The cycle in which the start edge is detected counts as the first of the
    // half bit, which is why the counter is preloaded with 1 while idle.
    assign tick = (state_reg == S_START) ? (cnt_reg == HALF_LAST) : (cnt_reg == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!rxs) state_next = S_START;
            S_START: if (tick) state_next = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (tick && bit_reg == BIT_LAST) state_next = S_STOP;
            S_STOP:  if (tick) state_next = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        valid_next = (state_reg == S_STOP) && tick && rxs;
        err_next   = (state_reg == S_STOP) && tick && !rxs;
        idle       = (state_reg == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= valid_next;
            frame_err  <= err_next;
            if (state_reg == S_IDLE) begin
                cnt_reg <= CNT_W'(1);
                bit_reg <= '0;
            end else if (tick) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (state_reg == S_DATA && tick) begin
                shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                bit_reg   <= bit_reg + BIT_W'(1);
            end
        end
    end

    assign byte_data = shift_reg;

endmodule

// File: rtl/uart_rx_word.sv
// Assembles WORD_BYTES received bytes (first byte in the MSBs) into one word,
// drops stale partial words after line silence, and presents words over valid/ready.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          rx_serial,
    output logic [DATA_BITS*WORD_BYTES-1:0] out_word,
    output logic                          out_valid,
    input  logic                          in_ready,
    output logic                          out_frame_err,
    output logic                          out_overrun
);
    localparam int WORD_W   = DATA_BITS * WORD_BYTES;
    localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SH_N     = (WORD_BYTES > 1) ? WORD_BYTES - 1 : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (TO_LIMIT > 0) ? TO_W'(TO_LIMIT - 1) : '0;

    logic [DATA_BITS-1:0]           rx_byte;
    logic                           rx_valid;
    logic                           rx_err;
    logic                           rx_idle;
    logic [IDX_W-1:0]               idx_reg;
    logic [TO_W-1:0]                to_cnt_reg;
    logic                           to_hit;
    logic [SH_N-1:0][DATA_BITS-1:0] shadow_reg;
    logic [WORD_W-1:0]              done_word;
    logic                           word_done;
    logic [WORD_W-1:0]              word_reg;
    logic                           valid_reg;
    logic                           overrun_reg;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (in_clk),
        .rst       (in_rst),
        .rx_serial (rx_serial),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err),
        .idle      (rx_idle)
    );

    // Silence is only measured while a partial word is pending; any start bit
    // takes the receiver out of idle and so restarts the count.
    assign to_hit = (TO_LIMIT > 0) && rx_idle && (idx_reg != '0) && (to_cnt_reg == TO_LAST);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)                                 to_cnt_reg <= '0;
        else if (!rx_idle || idx_reg == '0 || to_hit) to_cnt_reg <= '0;
        else                                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)        idx_reg <= '0;
        else if (rx_err)   idx_reg <= '0;
        else if (rx_valid) idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        else if (to_hit)   idx_reg <= '0;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            shadow_reg <= '0;
        end else begin
            for (int k = 0; k < WORD_BYTES - 1; k++) begin
                if (rx_valid && idx_reg == IDX_W'(k)) shadow_reg[k] <= rx_byte;
            end
        end
    end

    // The final byte bypasses the shadow so the word is ready the cycle it lands.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_asm
        if (gi == WORD_BYTES - 1) begin : g_last
            assign done_word[DATA_BITS*(WORD_BYTES-gi)-1 -: DATA_BITS] = rx_byte;
        end else begin : g_prev
            assign done_word[DATA_BITS*(WORD_BYTES-gi)-1 -: DATA_BITS] = shadow_reg[gi];
        end
    end

    assign word_done = rx_valid && (idx_reg == IDX_LAST);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (word_done) begin
                if (!valid_reg || in_ready) begin
                    word_reg  <= done_word;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && in_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_word      = word_reg;
    assign out_valid     = valid_reg;
    assign out_overrun   = overrun_reg;
    assign out_frame_err = rx_err;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: a byte-level event model predicts the
// handshake outputs every cycle; literal expectations pin each scenario.
module tb_uart_rx_word;

    localparam int CLKS     = 87;
    localparam int WB       = 2;
    localparam int TO_BITS  = 16;
    localparam int LAT      = 829;
    localparam int TO_LIMIT = TO_BITS * CLKS;

    logic          in_clk    = 1'b0;
    logic          in_rst    = 1'b1;
    logic          rx_serial = 1'b1;
    logic          in_ready  = 1'b0;
    logic [8*WB-1:0] out_word;
    logic          out_valid;
    logic          out_frame_err;
    logic          out_overrun;

    uart_rx_word #(
        .CLKS_PER_BIT(CLKS),
        .WORD_BYTES  (WB),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .rx_serial    (rx_serial),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .out_frame_err(out_frame_err),
        .out_overrun  (out_overrun)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One entry per byte put on the line: the edge at which its effect on the
    // word outputs becomes visible, when its start bit fell, its value and stop status.
    typedef struct {
        int         e;
        int         start;
        logic [7:0] val;
        bit         good;
    } ev_t;

    ev_t evq[$];

    logic [7:0]      m_bytes [WB];
    int              m_idx      = 0;
    int              m_last     = -1000000;
    logic            m_valid    = 1'b0;
    logic [8*WB-1:0] m_word     = '0;
    logic            ready_prev = 1'b0;
    logic            prev_valid = 1'b0;
    int              fe_exp     = 0;
    int              fe_obs     = 0;
    int              ovr_obs    = 0;
    int              rise_cyc   = -1;

    always @(negedge in_clk) begin
        ev_t             ev;
        bit              done;
        bit              ovr_exp;
        logic [8*WB-1:0] w;
        if (in_rst) begin
            m_idx   = 0;
            m_valid = 1'b0;
            m_word  = '0;
            evq.delete();
        end else begin
            done    = 1'b0;
            ovr_exp = 1'b0;
            w       = '0;
            while (evq.size() > 0 && evq[0].e <= cyc) begin
                ev = evq.pop_front();
                if (!ev.good) begin
                    m_idx = 0;
                    fe_exp++;
                end else begin
                    if (m_idx != 0 && (ev.start - m_last) >= TO_LIMIT) m_idx = 0;
                    m_bytes[m_idx] = ev.val;
                    m_last = ev.e;
                    if (m_idx == WB - 1) begin
                        w = '0;
                        for (int k = 0; k < WB; k++) w = (w << 8) | (8*WB)'(m_bytes[k]);
                        done  = 1'b1;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (done) begin
                if (!m_valid || ready_prev) begin
                    m_word  = w;
                    m_valid = 1'b1;
                end else begin
                    ovr_exp = 1'b1;
                end
            end else if (m_valid && ready_prev) begin
                m_valid = 1'b0;
            end
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_word", 32'(out_word), 32'(m_word));
            chk("out_overrun", 32'(out_overrun), 32'(ovr_exp));
            if (out_frame_err) fe_obs++;
            if (out_overrun) ovr_obs++;
            if (out_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = out_valid;
        ready_prev = in_ready;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit stop_ok, output int f);
        ev_t ev;
        tick(2);
        rx_serial = 1'b0;
        f         = cyc;
        ev.e      = f + LAT;
        ev.start  = f;
        ev.val    = v;
        ev.good   = stop_ok;
        evq.push_back(ev);
        tick(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = v[i];
            tick(CLKS);
        end
        rx_serial = stop_ok;
        tick(CLKS);
        rx_serial = 1'b1;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int f;
        in_rst    = 1'b1;
        rx_serial = 1'b1;
        in_ready  = 1'b0;
        tick(3);
        chk("rst_word", 32'(out_word), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_frame_err", 32'(out_frame_err), 32'h0);
        chk("rst_overrun", 32'(out_overrun), 32'h0);
        in_rst = 1'b0;
        tick(5);

        // Byte pair straight through
        in_ready = 1'b1;
        send_byte(8'h3F, 1'b1, f);
        send_byte(8'hFF, 1'b1, f);
        tick(5);
        chk("pair_word", 32'(out_word), 32'h3FFF);
        chk("pair_latency", 32'(rise_cyc), 32'(f + 829));
        chk("pair_frame_err_cnt", 32'(fe_obs), 32'd0);
        chk("pair_overrun_cnt", 32'(ovr_obs), 32'd0);

        // Short low glitch is ignored
        rx_serial = 1'b0;
        tick(20);
        rx_serial = 1'b1;
        tick(100);
        send_byte(8'h12, 1'b1, f);
        send_byte(8'h34, 1'b1, f);
        tick(5);
        chk("glitch_word", 32'(out_word), 32'h1234);
        chk("glitch_frame_err_cnt", 32'(fe_obs), 32'd0);

        // Framing error discards the bad byte
        send_byte(8'h55, 1'b0, f);
        tick(20);
        send_byte(8'hA5, 1'b1, f);
        send_byte(8'h01, 1'b1, f);
        tick(5);
        chk("ferr_word", 32'(out_word), 32'hA501);
        chk("ferr_pulse_cnt", 32'(fe_obs), 32'd1);
        chk("ferr_model_cnt", 32'(fe_obs), 32'(fe_exp));

        // Backpressure: second word is dropped
        in_ready = 1'b0;
        send_byte(8'h12, 1'b1, f);
        send_byte(8'h34, 1'b1, f);
        send_byte(8'h56, 1'b1, f);
        send_byte(8'h78, 1'b1, f);
        tick(5);
        chk("bp_word_held", 32'(out_word), 32'h1234);
        chk("bp_valid_held", 32'(out_valid), 32'h1);
        chk("bp_overrun_cnt", 32'(ovr_obs), 32'd1);
        in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
        chk("bp_valid_after_accept", 32'(out_valid), 32'h0);
        chk("bp_word_after_accept", 32'(out_word), 32'h1234);

        // Inter-byte timeout drops a lone first byte
        in_ready = 1'b1;
        send_byte(8'h3F, 1'b1, f);
        tick(TO_LIMIT + 10);
        send_byte(8'h01, 1'b1, f);
        send_byte(8'h02, 1'b1, f);
        tick(5);
        chk("timeout_word", 32'(out_word), 32'h0102);

        // Asynchronous reset in the middle of a byte
        in_ready = 1'b0;
        send_byte(8'h11, 1'b1, f);
        send_byte(8'h22, 1'b1, f);
        tick(5);
        chk("prerst_valid", 32'(out_valid), 32'h1);
        chk("prerst_word", 32'(out_word), 32'h1122);
        tick(2);
        rx_serial = 1'b0;
        tick(CLKS * 2 + 40);
        @(negedge in_clk);
        #2;
        in_rst    = 1'b1;
        rx_serial = 1'b1;
        #1;
        chk("async_rst_word", 32'(out_word), 32'h0);
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_frame_err", 32'(out_frame_err), 32'h0);
        chk("async_rst_overrun", 32'(out_overrun), 32'h0);
        tick(3);
        in_rst = 1'b0;
        tick(5);
        in_ready = 1'b1;
        send_byte(8'hAB, 1'b1, f);
        send_byte(8'hCD, 1'b1, f);
        tick(5);
        chk("postrst_word", 32'(out_word), 32'hABCD);
        chk("final_frame_err_cnt", 32'(fe_obs), 32'(fe_exp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Serial-side front end that sits directly upstream of the main processing block.
- Samples the asynchronous UART line (8N1, LSB first) and assembles WORD_BYTES consecutive bytes into one parallel word.
- Delivers the word over a valid/ready handshake.
- Reports framing errors and overruns, and discards partial words after inter-byte silence.

Parameters:
- CLKS_PER_BIT, 87, in_clk cycles per UART bit (10 MHz / 115200 baud); must be >= 8.
- WORD_BYTES, 2, bytes per assembled word; the first received byte goes to the MS byte.
- TIMEOUT_BITS, 16, idle bit-times after which a partial word is dropped; 0 disables the timeout.

Ports:
- in_clk  input  1  system clock
- in_rst  input  1  asynchronous, active-high reset
- rx_serial  input  1  UART line, idle high, asynchronous to in_clk
- out_word  output  8*WORD_BYTES  assembled word, first byte in the MSBs
- out_valid  output  1  out_word holds an unconsumed word
- in_ready  input  1  consumer accepts out_word when in_ready && out_valid
- out_frame_err  output  1  one-cycle pulse on a bad stop bit
- out_overrun  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; all flops clear on in_rst rising, with no clock required.
- Reset values:
  - out_word=0, out_valid=0, out_frame_err=0, out_overrun=0.
  - Synchronizer flops = 1.
  - Byte index = 0, timeout counter = 0, FSM = IDLE.
- Synchronizer: two-flop on rx_serial. Below, "rxs" is the synchronized line.
- Byte FSM:
  - IDLE: when rxs==0 at cycle t0, clear the bit counter and go to START.
  - START: count CLKS_PER_BIT/2 (integer division) cycles, then sample rxs at t0+CLKS_PER_BIT/2.
    - rxs==1 is a glitch: go to IDLE with no flags raised.
    - Otherwise go to DATA.
  - DATA: sample bit i (i=0..7) at t0+CLKS_PER_BIT/2+CLKS_PER_BIT*(i+1) and shift it in LSB first. After bit 7, go to STOP.
  - STOP: sample at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
    - rxs==1: the byte is good; hand it to the assembler and go to IDLE.
    - rxs==0: pulse out_frame_err for 1 cycle, discard the byte, reset the byte index to 0, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE.
- Latency, CLKS_PER_BIT=87:
  - The stop sample falls 826 cycles after t0.
  - out_valid rises 1 cycle later, i.e. 829 in_clk edges after the rx_serial falling edge of the last byte's start bit.
- Word assembler:
  - Byte k (k=0..WORD_BYTES-1) is written to bits [8*(WORD_BYTES-k)-1 -: 8] of a shadow register.
  - Completion of the byte at index WORD_BYTES-1 means the word is done; the index then returns to 0.
- Inter-byte timeout:
  - Counts cycles while the FSM is IDLE and the index is nonzero.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT clears the index to 0 and drops the partial bytes, with no flag.
  - Any start bit clears the counter.
- Output handshake on word completion:
  - out_valid==0: load out_word and set out_valid=1.
  - out_valid==1 && in_ready==1 in the same cycle: load the new word; out_valid stays 1.
  - out_valid==1 && in_ready==0: drop the new word, keep the old one, pulse out_overrun.
- Holding and consuming:
  - While out_valid==1, out_word is stable until accepted.
  - Accept without completion clears out_valid on the next edge; out_word keeps its last value.
- Reset mid-byte or mid-word: everything returns to reset values immediately. A line still low after reset release starts a new byte only from the IDLE check, which the bench must tolerate.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - DATA_BITS=8 and the default CLKS_PER_BIT=87.
- One sub-module, uart_rx_byte:
  - Contains the synchronizer and byte FSM.
  - Outputs byte[7:0], byte_valid (1-cycle pulse), frame_err (pulse) and idle.
- uart_rx_word instantiates it and adds the assembler, the timeout and the handshake register.

Test Plan:
- Byte pair: send 0x3F then 0xFF with in_ready=1 -> out_word=16'h3FFF; out_valid high for exactly 1 cycle, 829 clocks after the second start edge; no error pulses.
- Glitch: hold rx_serial low for 20 clocks, then high -> no byte, no flags; a following 0x12, 0x34 yields 16'h1234.
- Framing error: send 0x55 with stop bit=0, then 0xA5, 0x01 -> one out_frame_err pulse; the next word is 16'hA501, not 16'h55A5.
- Backpressure: with in_ready=0, send word 0x1234 then 0x5678 -> out_word stays 16'h1234, out_overrun pulses once. Then raise in_ready for 1 cycle -> out_valid=0 on the next edge.
- Timeout: send 0x3F, idle for 16*87+10 clocks, then send 0x01, 0x02 -> out_word=16'h0102.
- Reset mid-operation: assert in_rst during DATA of byte 1 -> all outputs 0 asynchronously. After release, the pair 0xAB, 0xCD yields 16'hABCD.
